// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request channel.
// Each access takes WAIT_CYCLES wait states, then holds a registered response until it is consumed.
module mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [3:0]             cnt;
  logic                   we_q;
  logic [15:0]            addr_q;
  logic [15:0]            wdata_q;
  logic [15:0]            mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0]   idx;
  logic                   handshake;
  logic                   access;
  logic                   out_of_range;

  assign handshake    = req_valid && req_ready;
  assign access       = (state == WAIT) && (cnt == 4'd0);
  assign idx          = addr_q[ADDR_BITS-1:0];
  assign out_of_range = (addr_q >> ADDR_BITS) != 16'd0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = WAIT;
      WAIT:    if (cnt == 4'd0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only, so rsp_valid has no input path.
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
    end else if (handshake) begin
      cnt     <= WAIT_INIT;
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response data is cleared as the response is consumed, so it reads 0 outside RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= 16'd0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_err   <= out_of_range;
      rsp_rdata <= (!out_of_range && !we_q) ? mem[idx] : 16'd0;
    end else if (state == RESP && rsp_ready) begin
      rsp_rdata <= 16'd0;
      rsp_err   <= 1'b0;
    end
  end

  // Memory has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && access && we_q && !out_of_range)
      mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
  logic [15:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
  logic [15:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  int          tests = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .busy(a_busy)
  );

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .busy(b_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata);
    a_req_valid = valid;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
  endtask

  // One transaction on instance A; hold = extra RESP cycles with rsp_ready low,
  // glitch = keep driving a different request while the access is pending.
  task automatic runTxn(input string tag, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input int hold, input logic glitch,
                        input logic [15:0] exp_rdata, input logic exp_err);
    int n;
    checkOutput({tag, "_req_ready"}, 32'(a_req_ready), 32'd1);
    applyStimulus(1'b1, we, addr, wdata);
    tick;
    n = 1;
    if (glitch) applyStimulus(1'b1, we, addr + 16'd1, 16'h0);
    else        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    while (!a_rsp_valid && n < 20) begin
      tick;
      n++;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'd4);
    checkOutput({tag, "_rdata"}, 32'(a_rsp_rdata), 32'(exp_rdata));
    checkOutput({tag, "_err"}, 32'(a_rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      tick;
      checkOutput({tag, "_hold_valid"}, 32'(a_rsp_valid), 32'd1);
      checkOutput({tag, "_hold_rdata"}, 32'(a_rsp_rdata), 32'(exp_rdata));
      checkOutput({tag, "_hold_err"}, 32'(a_rsp_err), 32'(exp_err));
      checkOutput({tag, "_hold_req_ready"}, 32'(a_req_ready), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    a_rsp_ready = 1'b1;
    tick;
    a_rsp_ready = 1'b0;
    checkOutput({tag, "_done_busy"}, 32'(a_busy), 32'd0);
    checkOutput({tag, "_done_valid"}, 32'(a_rsp_valid), 32'd0);
    checkOutput({tag, "_done_rdata"}, 32'(a_rsp_rdata), 32'd0);
  endtask

  initial begin
    logic [8:0] rmask;
    logic [8:0] vmask;
    int         n;
    rst = 1'b1;
    a_rsp_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 16'h0; b_req_wdata = 16'h0;
    b_rsp_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    checkOutput("reset_rsp_valid", 32'(a_rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", 32'(a_rsp_rdata), 32'd0);
    checkOutput("reset_rsp_err", 32'(a_rsp_err), 32'd0);
    checkOutput("reset_busy", 32'(a_busy), 32'd0);
    checkOutput("reset_req_ready", 32'(a_req_ready), 32'd1);

    // Instance B: store then loads back to back with rsp_ready tied high.
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 16'h0007; b_req_wdata = 16'h00C3;
    rmask = '0;
    vmask = '0;
    for (int c = 0; c < 9; c++) begin
      rmask[c] = b_req_ready;
      vmask[c] = b_rsp_valid;
      if (c == 2) checkOutput("b_store_rdata", 32'(b_rsp_rdata), 32'd0);
      if (c == 5) checkOutput("b_load_rdata", 32'(b_rsp_rdata), 32'h00C3);
      if (c == 5) checkOutput("b_load_err", 32'(b_rsp_err), 32'd0);
      if (c == 1) b_req_we = 1'b0;
      if (c == 8) b_req_valid = 1'b0;
      tick;
    end
    checkOutput("b_accept_every_3", 32'(rmask), 32'h049);
    checkOutput("b_rsp_valid_t_plus_2", 32'(vmask), 32'h124);
    b_rsp_ready = 1'b0;

    // Instance A: store/load round trip, range errors, stalls, address changes.
    runTxn("st_beef", 1'b1, 16'h0012, 16'hBEEF, 0, 1'b0, 16'h0000, 1'b0);
    runTxn("ld_beef", 1'b0, 16'h0012, 16'h0000, 0, 1'b0, 16'hBEEF, 1'b0);
    runTxn("st_5555", 1'b1, 16'h0000, 16'h5555, 0, 1'b0, 16'h0000, 1'b0);
    runTxn("st_oor", 1'b1, 16'h0100, 16'h1234, 0, 1'b0, 16'h0000, 1'b1);
    runTxn("ld_oor", 1'b0, 16'h0100, 16'h0000, 0, 1'b0, 16'h0000, 1'b1);
    runTxn("ld_00", 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 16'h5555, 1'b0);
    runTxn("ld_stall", 1'b0, 16'h0012, 16'h0000, 4, 1'b0, 16'hBEEF, 1'b0);
    runTxn("st_03", 1'b1, 16'h0003, 16'h1111, 0, 1'b0, 16'h0000, 1'b0);
    runTxn("st_04", 1'b1, 16'h0004, 16'h2222, 0, 1'b0, 16'h0000, 1'b0);
    runTxn("ld_addr_change", 1'b0, 16'h0003, 16'h0000, 0, 1'b1, 16'h1111, 1'b0);

    // Reset in WAIT abandons the store to 0x05.
    runTxn("st_7777", 1'b1, 16'h0005, 16'h7777, 0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h0005, 16'hAAAA);
    tick;
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("wait_busy", 32'(a_busy), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkOutput("rst_wait_busy", 32'(a_busy), 32'd0);
    checkOutput("rst_wait_req_ready", 32'(a_req_ready), 32'd1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (a_rsp_valid) n++;
      tick;
    end
    checkOutput("rst_wait_no_rsp", 32'(n), 32'd0);

    // A request coinciding with reset is not taken.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h0005, 16'hAAAA);
    tick;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("rst_req_busy", 32'(a_busy), 32'd0);
    tick;
    runTxn("ld_05", 1'b0, 16'h0005, 16'h0000, 0, 1'b0, 16'h7777, 1'b0);

    // Reset in RESP drops the response.
    applyStimulus(1'b1, 1'b0, 16'h0012, 16'h0000);
    tick;
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    n = 1;
    while (!a_rsp_valid && n < 20) begin
      tick;
      n++;
    end
    checkOutput("resp_reached", 32'(a_rsp_valid), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkOutput("rst_resp_valid", 32'(a_rsp_valid), 32'd0);
    checkOutput("rst_resp_rdata", 32'(a_rsp_rdata), 32'd0);
    checkOutput("rst_resp_busy", 32'(a_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, giving the number of implemented 16-bit word locations as 2**ADDR_BITS.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, giving wait states per access (range 0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  the initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  the responder accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  16  word address.
REQ-009 SHALL have port req_wdata  input  16  store data.
REQ-010 SHALL have port rsp_valid  output  1  the response is present.
REQ-011 SHALL have port rsp_ready  input  1  the initiator consumes the response.
REQ-012 SHALL have port rsp_rdata  output  16  load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  the address was out of range.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE.
REQ-017 SHALL accept a request (handshake) when req_valid && req_ready, capturing req_we, req_addr and req_wdata into internal registers.
REQ-018 On handshake, SHALL load the wait counter with WAIT_CYCLES and enter WAIT.
REQ-019 In WAIT, SHALL decrement the counter each cycle while it is nonzero.
REQ-020 In WAIT, when the counter is 0, SHALL perform the access and enter RESP in the same edge.
REQ-021 With WAIT_CYCLES=0, SHALL spend exactly one cycle in WAIT.
REQ-022 SHALL assert rsp_valid first in the cycle T+WAIT_CYCLES+2, where T is the handshake cycle.
REQ-023 Access SHALL be out of range when req_addr[15:ADDR_BITS] is nonzero.
REQ-024 An out-of-range access SHALL set rsp_err=1 and rsp_rdata=0, and SHALL modify no memory location.
REQ-025 An in-range store SHALL write the captured wdata to mem[addr[ADDR_BITS-1:0]], and SHALL give rsp_rdata=0 and rsp_err=0.
REQ-026 An in-range load SHALL register mem[addr] into rsp_rdata, with rsp_err=0.
REQ-027 In RESP, SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1.
REQ-028 In RESP with rsp_ready=1, SHALL return to IDLE on that edge; a new request SHALL be accepted no earlier than the following cycle.
REQ-029 Changes on req_* lines while not in IDLE SHALL be ignored.
REQ-030 A load following a store to the same address SHALL return the stored value.
REQ-031 SHALL have no combinational path from any input to rsp_valid, rsp_rdata or rsp_err.
REQ-032 rsp_rdata and rsp_err SHALL read 0 whenever rsp_valid=0.

Reset
REQ-033 With rst=1 at a rising edge, SHALL enter IDLE, clear the wait counter, and drive rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=1 from the next cycle.
REQ-034 A reset during WAIT SHALL abandon the pending access, with no memory write.
REQ-035 A reset during RESP SHALL drop the response.
REQ-036 Reset SHALL NOT clear memory contents.
REQ-037 A request presented in the same cycle as rst=1 SHALL NOT be accepted.

Verification
REQ-038 SHALL cover: store 0xBEEF to addr 0x0012 then load 0x0012, WAIT_CYCLES=2 -> load gives rsp_rdata=0xBEEF, rsp_err=0, with rsp_valid first at T+4.
REQ-039 SHALL cover: load from addr 0x0100 with ADDR_BITS=8 -> rsp_err=1 and rsp_rdata=0; a prior store of 0x1234 to 0x0100 leaves mem[0x00] unchanged.
REQ-040 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and data stable all 5 cycles, req_ready=0 throughout, IDLE one cycle after rsp_ready=1.
REQ-041 SHALL cover: WAIT_CYCLES=0 -> rsp_valid at T+2; back-to-back requests with rsp_ready tied high -> one accepted every 3 cycles.
REQ-042 SHALL cover: rst=1 during WAIT of a store of 0xAAAA to 0x0005 -> mem[0x05] keeps its old value, rsp_valid never asserts, busy=0 after reset.
REQ-043 SHALL cover: req_addr changed from 0x0003 to 0x0004 during WAIT -> the response reflects 0x0003.
